// File: rtl/mat_result_tx.sv
// mat_result_tx: frames the 2x2 result matrix C into a byte stream for the UART.
// Frame: HEADER, MAT_TAG, job_id, c11, c12, c21, c22 [, XOR checksum].
// One byte is offered at a time on tx_byte/tx_valid. It is held until tx_ready.
module mat_result_tx #(
    parameter logic [7:0]  HEADER      = 8'hFF,
    parameter logic [7:0]  MAT_TAG     = 8'h02,
    parameter bit          CHECKSUM_EN = 1'b1,
    parameter int unsigned GAP_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] job_id,
    input  logic [7:0] c11,
    input  logic [7:0] c12,
    input  logic [7:0] c21,
    input  logic [7:0] c22,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    localparam logic [2:0] LAST     = CHECKSUM_EN ? 3'd7 : 3'd6;
    // The counter is loaded with GAP_CYCLES-1 so that GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t     state, state_nxt;
    logic [2:0] idx, idx_nxt;
    logic [7:0] gap_cnt, gap_nxt;
    logic [7:0] job_q, c11_q, c12_q, c21_q, c22_q;
    logic [7:0] csum;
    logic [7:0] byte_nxt;
    logic       cap;
    logic       xfer;

    assign xfer = tx_valid && tx_ready;
    assign csum = job_q ^ c11_q ^ c12_q ^ c21_q ^ c22_q;

    // State register; reset aborts any frame in progress at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SEND;
            SEND: if (xfer) begin
                if (idx == LAST)         state_nxt = DONE;
                else if (GAP_CYCLES > 0) state_nxt = GAP;
                else                     state_nxt = SEND;
            end
            GAP:  if (gap_cnt == 8'd0) state_nxt = SEND;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs and next values of the frame datapath.
    always_comb begin
        idx_nxt = idx;
        gap_nxt = gap_cnt;
        cap     = 1'b0;
        busy    = (state != IDLE);
        done    = (state == DONE);
        case (state)
            IDLE: if (start) begin
                cap     = 1'b1;
                idx_nxt = 3'd0;
            end
            SEND: if (xfer && idx != LAST) begin
                idx_nxt = idx + 3'd1;
                gap_nxt = GAP_LOAD;
            end
            GAP:  if (gap_cnt != 8'd0) gap_nxt = gap_cnt - 8'd1;
            default: ;
        endcase
        // Header is a constant, so index 0 is valid even on the capture cycle.
        case (idx_nxt)
            3'd0:    byte_nxt = HEADER;
            3'd1:    byte_nxt = MAT_TAG;
            3'd2:    byte_nxt = job_q;
            3'd3:    byte_nxt = c11_q;
            3'd4:    byte_nxt = c12_q;
            3'd5:    byte_nxt = c21_q;
            3'd6:    byte_nxt = c22_q;
            default: byte_nxt = csum;
        endcase
    end

    // Frame datapath: captured operands, byte index, gap counter and registered tx outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= 3'd0;
            gap_cnt  <= 8'd0;
            job_q    <= 8'd0;
            c11_q    <= 8'd0;
            c12_q    <= 8'd0;
            c21_q    <= 8'd0;
            c22_q    <= 8'd0;
            tx_valid <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            idx      <= idx_nxt;
            gap_cnt  <= gap_nxt;
            tx_valid <= (state_nxt == SEND);
            if (state_nxt == SEND) tx_byte <= byte_nxt;
            if (cap) begin
                job_q <= job_id;
                c11_q <= c11;
                c12_q <= c12;
                c21_q <= c21;
                c22_q <= c22;
            end
        end
    end
endmodule

// File: doc/mat_result_tx.md
Name: mat_result_tx

Overview:
- Transmit-side framer for the matrix multiply link. It sends the 2x2 result matrix C back to the host through the UART transmitter.
- It mirrors the inbound packet format, which is header, matrix tag, job id and 4 elements, and adds an optional XOR checksum.
- It sits between the mat_mul output registers / top-level FSM and the uart tx_byte / tx_enable path. The FSM pulses start once C is valid; this block drives one byte at a time under a valid/ready handshake.

Parameters:
- HEADER, 8'hFF, first byte of every frame.
- MAT_TAG, 8'h02, matrix tag byte. 0x00 is A and 0x01 is B inbound; 0x02 is C outbound.
- CHECKSUM_EN, 1, when 1 append an XOR checksum byte (8-byte frame); when 0 the frame is 7 bytes.
- GAP_CYCLES, 0, minimum idle clk cycles inserted after each accepted byte before the next tx_valid assertion (0..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to send a frame; sampled only in IDLE.
- job_id  in  8  job number echoed in the frame; captured on accepted start.
- c11  in  8  result element; captured on accepted start.
- c12  in  8  result element; captured on accepted start.
- c21  in  8  result element; captured on accepted start.
- c22  in  8  result element; captured on accepted start.
- tx_ready  in  1  UART transmitter can accept a byte this cycle.
- tx_byte  out  8  byte presented to the UART.
- tx_valid  out  1  tx_byte is valid; a transfer occurs when tx_valid && tx_ready.
- busy  out  1  frame in progress (not IDLE).
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state=IDLE, tx_valid=0, tx_byte=8'h00, busy=0, done=0, byte index=0, gap counter=0, captured registers=0.
- Reset asserted mid-frame aborts immediately. No further bytes are sent and no done pulse is generated.
- States:
  - IDLE: busy=0, tx_valid=0. If start=1, capture job_id and c11..c22, set idx=0, go to SEND next cycle. busy=1 from that cycle on.
  - SEND: tx_valid=1 and tx_byte=frame[idx], both registered.
    - Hold tx_byte and tx_valid stable until tx_ready=1.
    - On transfer with idx=LAST: go to DONE.
    - On transfer otherwise: idx+1, then go to GAP if GAP_CYCLES>0, else stay in SEND. The next byte is presented on the following cycle with no bubble.
  - GAP: tx_valid=0; count GAP_CYCLES cycles, then return to SEND.
  - DONE: tx_valid=0, done=1 for exactly one cycle, busy=1; next state IDLE.
- Frame bytes, in order:
  - idx0 = HEADER
  - idx1 = MAT_TAG
  - idx2 = job_id
  - idx3 = c11
  - idx4 = c12
  - idx5 = c21
  - idx6 = c22
  - idx7 = checksum, only when CHECKSUM_EN=1
- LAST is 7 when CHECKSUM_EN=1, else 6.
- Checksum = job_id ^ c11 ^ c12 ^ c21 ^ c22, computed from the captured values. HEADER and MAT_TAG are excluded.
- Captured values are frozen for the whole frame. Input changes after start do not alter the frame in progress.
- start while busy (including the DONE cycle) is ignored and not queued.
- start and tx_ready asserted together in IDLE: the first byte is not transferred that cycle. tx_valid rises the next cycle.
- tx_ready held high continuously with GAP_CYCLES=0:
  - 8-byte frame: 8 consecutive transfer cycles, then done.
  - Latency from start to done is 10 cycles: 1 capture cycle, 8 transfer cycles, 1 DONE cycle.
- tx_ready low indefinitely: the block waits forever in SEND with stable outputs. There is no timeout.
- Back-to-back frames: start may be accepted in IDLE on the cycle after DONE, so the minimum frame period is frame length + 2 cycles.

Test Plan:
- Basic frame: rst pulse, then start with job_id=0x05 and C=0x13,0x16,0x2B,0x32 (A=[1 2;3 4], B=[5 6;7 8]); tx_ready=1 always. Required: bytes FF,02,05,13,16,2B,32,19 on consecutive cycles, then a single done pulse; start to done = 10 cycles.
- Backpressure: same stimulus; tx_ready low for 5 cycles on every 3rd byte. Required: tx_byte and tx_valid stable while stalled; identical byte sequence; no duplicated or dropped bytes.
- Input freeze and start-while-busy: change c11 to 0xAA and pulse start during byte 3. Required: c11 still sent as 0x13, checksum 0x19, and exactly one frame sent.
- Parameter variants:
  - CHECKSUM_EN=0: 7-byte frame FF,02,05,13,16,2B,32.
  - GAP_CYCLES=3: exactly 3 tx_valid=0 cycles between every pair of accepted bytes.
- Async reset mid-frame: assert rst between clock edges during byte 4. Required: tx_valid, busy and done go to 0 immediately with no done pulse; the next start produces a complete, correct frame.
- Back-to-back: issue start on the cycle after done with job_id=0x06 and C=0x00,0x00,0x00,0x01. Required: second frame FF,02,06,00,00,00,01,07 begins 1 cycle after the start is accepted.
